// File: rtl/fetch_pkg.sv
// Shared widths, opcode and types for the instruction fetch stage.
package fetch_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } buf_entry_t;

    function automatic logic is_halt(input logic [DATA_W-1:0] word);
        return (word[DATA_W-1 -: 4] == HALT_OPCODE);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO of {pc, data}. Slot 0 is always the head, so the
// head and valid outputs come straight from registers.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  buf_entry_t push_entry_i,
    output buf_entry_t head_o,
    output logic [1:0] count_o,
    output logic       valid_o
);

    buf_entry_t slot0_q, slot0_d;
    buf_entry_t slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic       valid_q;

    // Next contents: flush wins over push; a pop shifts slot 1 into the head.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push_i) begin
                        slot0_d = push_entry_i;
                        count_d = 2'd1;
                    end else begin
                        count_d = 2'd0;
                    end
                end
                2'd1: begin
                    if (push_i && pop_i) begin
                        slot0_d = push_entry_i;
                    end else if (push_i) begin
                        slot1_d = push_entry_i;
                        count_d = 2'd2;
                    end else if (pop_i) begin
                        count_d = 2'd0;
                    end else begin
                        count_d = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_i) begin
                        slot0_d = slot1_q;
                        if (push_i) begin
                            slot1_d = push_entry_i;
                        end else begin
                            count_d = 2'd1;
                        end
                    end else begin
                        count_d = 2'd2;
                    end
                end
                default: begin
                    count_d = 2'd0;
                end
            endcase
        end
    end

    // Buffer storage, occupancy and registered valid flag.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
            valid_q <= (count_d != 2'd0);
        end
    end

    assign head_o  = slot0_q;
    assign count_o = count_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one address per cycle to
// program_memory, buffers returned words and hands them to the decoder.
module fetch_unit #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    import fetch_pkg::*;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              halted_q, halted_d;

    logic              pop_s, push_s, issue_s, halt_cap_s, drain_done_s;
    logic              buf_valid_s;
    logic [1:0]        count_s;
    logic [2:0]        demand_s;
    buf_entry_t        push_entry_s, head_s;

    // A response is discarded rather than captured when a redirect lands with it.
    assign pop_s      = buf_valid_s && instr_ready;
    assign push_s     = inflight_q && !redirect;
    assign halt_cap_s = push_s && is_halt(mem_data);

    assign push_entry_s.pc   = inflight_pc_q;
    assign push_entry_s.data = mem_data;

    // Slots committed after this edge if nothing new is issued.
    assign demand_s = {1'b0, count_s} + {2'b00, inflight_q} - {2'b00, pop_s};

    assign issue_s = (state_q == RUN) && !redirect && !halt_cap_s
                     && (demand_s < 3'(BUF_DEPTH));

    assign drain_done_s = (count_s == 2'd0) || ((count_s == 2'd1) && pop_s);

    fetch_buffer u_buffer (
        .clk          (clk),
        .rst_ni       (rst),
        .push_i       (push_s),
        .pop_i        (pop_s),
        .flush_i      (redirect),
        .push_entry_i (push_entry_s),
        .head_o       (head_s),
        .count_o      (count_s),
        .valid_o      (buf_valid_s)
    );

    // Next-state, PC and in-flight tracking.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        halted_d      = halted_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else begin
                    pc_d = pc_q;
                end
                if (enable) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN, DRAIN, HALTED: begin
                if (redirect) begin
                    state_d  = RUN;
                    pc_d     = redirect_pc;
                    halted_d = 1'b0;
                end else if (halt_cap_s) begin
                    state_d = DRAIN;
                end else if ((state_q == DRAIN) && drain_done_s) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
                if (issue_s) begin
                    pc_d          = pc_q + PC_ONE;
                    inflight_d    = 1'b1;
                    inflight_pc_d = pc_q;
                end else begin
                    inflight_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            halted_q      <= halted_d;
        end
    end

    assign mem_addr    = pc_q;
    assign instr       = head_s.data;
    assign instr_pc    = head_s.pc;
    assign instr_valid = buf_valid_s;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory model plus an expected-PC
// scoreboard derived from the fetch rules.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halted;

    logic [15:0] mem [256];
    logic [7:0]  exp_pc;
    int          tests = 0;
    int          fails = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // program_memory: samples the address at the edge, word valid next cycle
    always @(posedge clk) mem_data <= mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
        repeat (2) tick();
        tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr got %h want 00", mem_addr); end
        tests++; if (instr !== 16'h0000) begin fails++; $display("FAIL reset_instr got %h want 0000", instr); end
        tests++; if (instr_pc !== 8'h00) begin fails++; $display("FAIL reset_instr_pc got %h want 00", instr_pc); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", halted); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_start();
        logic [7:0] want_addr;
        instr_ready = 1'b1; enable = 1'b1;
        tick();
        enable = 1'b0;
        tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL start_e0_addr got %h want 00", mem_addr); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL start_e0_valid got %b want 0", instr_valid); end
        tick();
        tests++; if (mem_addr !== 8'h01) begin fails++; $display("FAIL start_e1_addr got %h want 01", mem_addr); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL start_e1_valid got %b want 0", instr_valid); end
        tick();
        exp_pc = 8'h00;
        for (int k = 0; k < 10; k++) begin
            want_addr = exp_pc + 8'd2;
            tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL stream_valid got %b want 1", instr_valid); end
            tests++; if (instr_pc !== exp_pc) begin fails++; $display("FAIL stream_pc got %h want %h", instr_pc, exp_pc); end
            tests++; if (instr !== mem[exp_pc]) begin fails++; $display("FAIL stream_data got %h want %h", instr, mem[exp_pc]); end
            tests++; if (mem_addr !== want_addr) begin fails++; $display("FAIL stream_addr got %h want %h", mem_addr, want_addr); end
            exp_pc++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] hd;
        logic [7:0] want_addr;
        hd = exp_pc;
        want_addr = hd + 8'd2;
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL bp_valid got %b want 1", instr_valid); end
            tests++; if (instr_pc !== hd) begin fails++; $display("FAIL bp_head got %h want %h", instr_pc, hd); end
            tests++; if (mem_addr !== want_addr) begin fails++; $display("FAIL bp_addr got %h want %h", mem_addr, want_addr); end
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL bp_resume_valid got %b want 1", instr_valid); end
            tests++; if (instr_pc !== exp_pc) begin fails++; $display("FAIL bp_resume_pc got %h want %h", instr_pc, exp_pc); end
            tests++; if (instr !== mem[exp_pc]) begin fails++; $display("FAIL bp_resume_data got %h want %h", instr, mem[exp_pc]); end
            exp_pc++;
            tick();
        end
    endtask

    task automatic test_random_backpressure();
        int         got;
        logic [7:0] diff;
        got = 0;
        for (int k = 0; k < 80; k++) begin
            if (instr_valid) begin
                diff = mem_addr - instr_pc;
                tests++; if (instr_pc !== exp_pc) begin fails++; $display("FAIL rnd_pc got %h want %h", instr_pc, exp_pc); end
                tests++; if (instr !== mem[exp_pc]) begin fails++; $display("FAIL rnd_data got %h want %h", instr, mem[exp_pc]); end
                tests++; if (diff > 8'd2) begin fails++; $display("FAIL rnd_ahead got %0d want <=2", diff); end
            end
            instr_ready = 1'($urandom_range(0, 1));
            if (instr_valid && instr_ready) begin
                exp_pc++;
                got++;
            end
            tick();
        end
        tests++; if (got < 20) begin fails++; $display("FAIL rnd_throughput got %0d want >=20", got); end
    endtask

    task automatic test_redirect(input logic [7:0] tgt, input logic stall);
        logic [7:0] next_addr;
        next_addr = tgt + 8'd1;
        if (stall) begin
            instr_ready = 1'b0;
            repeat (3) tick();
            tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL redir_prefill got %b want 1", instr_valid); end
        end
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = tgt;
        tick();
        redirect = 1'b0;
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL redir_r0_valid got %b want 0", instr_valid); end
        tests++; if (mem_addr !== tgt) begin fails++; $display("FAIL redir_r0_addr got %h want %h", mem_addr, tgt); end
        tick();
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL redir_r1_valid got %b want 0", instr_valid); end
        tests++; if (mem_addr !== next_addr) begin fails++; $display("FAIL redir_r1_addr got %h want %h", mem_addr, next_addr); end
        tick();
        exp_pc = tgt;
        for (int k = 0; k < 4; k++) begin
            tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL redir_valid got %b want 1", instr_valid); end
            tests++; if (instr_pc !== exp_pc) begin fails++; $display("FAIL redir_pc got %h want %h", instr_pc, exp_pc); end
            tests++; if (instr !== mem[exp_pc]) begin fails++; $display("FAIL redir_data got %h want %h", instr, mem[exp_pc]); end
            exp_pc++;
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [7:0] want [4];
        want = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'hFE;
        tick();
        redirect = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL wrap_valid got %b want 1", instr_valid); end
            tests++; if (instr_pc !== want[k]) begin fails++; $display("FAIL wrap_pc got %h want %h", instr_pc, want[k]); end
            tests++; if (instr !== mem[want[k]]) begin fails++; $display("FAIL wrap_data got %h want %h", instr, mem[want[k]]); end
            tick();
        end
    endtask

    task automatic test_halt();
        logic [7:0] base;
        logic [7:0] halt_pc;
        logic [7:0] stop_pc;
        logic [15:0] saved;
        int guard;
        base = 8'h80;
        halt_pc = base + 8'd3;
        stop_pc = base + 8'd4;
        saved = mem[halt_pc];
        mem[halt_pc] = 16'hF000;
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = base;
        tick();
        redirect = 1'b0;
        exp_pc = base;
        guard = 0;
        while ((exp_pc != stop_pc) && (guard < 12)) begin
            if (instr_valid) begin
                tests++; if (instr_pc !== exp_pc) begin fails++; $display("FAIL halt_pc got %h want %h", instr_pc, exp_pc); end
                tests++; if (instr !== mem[exp_pc]) begin fails++; $display("FAIL halt_data got %h want %h", instr, mem[exp_pc]); end
                exp_pc++;
            end
            tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_early got %b want 0", halted); end
            tick();
            guard++;
        end
        tests++; if (exp_pc !== stop_pc) begin fails++; $display("FAIL halt_words got %h want %h", exp_pc, stop_pc); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halted_flag got %b want 1", halted); end
            tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL halted_valid got %b want 0", instr_valid); end
            tests++; if (mem_addr !== stop_pc) begin fails++; $display("FAIL halted_addr got %h want %h", mem_addr, stop_pc); end
            tick();
        end
        redirect = 1'b1; redirect_pc = 8'h00;
        tick();
        redirect = 1'b0;
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL resume_halted got %b want 0", halted); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL resume_valid0 got %b want 0", instr_valid); end
        repeat (2) tick();
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL resume_valid got %b want 1", instr_valid); end
        tests++; if (instr_pc !== 8'h00) begin fails++; $display("FAIL resume_pc got %h want 00", instr_pc); end
        tests++; if (instr !== mem[0]) begin fails++; $display("FAIL resume_data got %h want %h", instr, mem[0]); end
        mem[halt_pc] = saved;
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        repeat (4) tick();
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL rmid_prefill got %b want 1", instr_valid); end
        #2;
        rst = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %b want 0", instr_valid); end
        tests++; if (instr !== 16'h0000) begin fails++; $display("FAIL rmid_instr got %h want 0000", instr); end
        tests++; if (instr_pc !== 8'h00) begin fails++; $display("FAIL rmid_pc got %h want 00", instr_pc); end
        tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL rmid_addr got %h want 00", mem_addr); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rmid_halted got %b want 0", halted); end
        tick();
        rst = 1'b1;
        instr_ready = 1'b1; enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (2) tick();
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL rmid_restart_valid got %b want 1", instr_valid); end
        tests++; if (instr_pc !== 8'h00) begin fails++; $display("FAIL rmid_restart_pc got %h want 00", instr_pc); end
        tests++; if (instr !== mem[0]) begin fails++; $display("FAIL rmid_restart_data got %h want %h", instr, mem[0]); end
    endtask

    task automatic test_idle_redirect();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'h20;
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++; if (mem_addr !== 8'h20) begin fails++; $display("FAIL idle_redir_addr got %h want 20", mem_addr); end
            tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL idle_redir_valid got %b want 0", instr_valid); end
            tick();
        end
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (2) tick();
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL idle_start_valid got %b want 1", instr_valid); end
        tests++; if (instr_pc !== 8'h20) begin fails++; $display("FAIL idle_start_pc got %h want 20", instr_pc); end
        tests++; if (instr !== mem[8'h20]) begin fails++; $display("FAIL idle_start_data got %h want %h", instr, mem[8'h20]); end
    endtask

    initial begin
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'hE;
            mem[i] = w;
        end
        test_reset();
        test_start();
        test_backpressure();
        test_random_backpressure();
        test_redirect(8'h40, 1'b0);
        test_redirect(8'($urandom_range(0, 255)), 1'b1);
        test_wrap();
        test_halt();
        test_reset_mid();
        test_idle_redirect();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of `program_memory`. It owns the program counter and drives the memory address each cycle. It captures the returned 16-bit word one cycle later and presents it to the decoder over a valid/ready handshake. It also supports PC redirect (branch/jump) and stops fetching on a HALT opcode.

## Interface
Parameters:
- `ADDR_W`, 8, program counter / memory address width
- `DATA_W`, 16, instruction width
- `RESET_PC`, 8'h00, PC value after reset
- `BUF_DEPTH`, 2, instruction buffer entries; fixed at 2, other values unsupported

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-low
- `enable` in 1: start fetching; sampled only in IDLE
- `mem_addr` out ADDR_W: address to `program_memory`, register output equal to PC
- `mem_data` in DATA_W: word from `program_memory`, valid the cycle after the address is sampled
- `instr` out DATA_W: head-of-buffer instruction
- `instr_pc` out ADDR_W: address of `instr`
- `instr_valid` out 1: `instr`/`instr_pc` valid
- `instr_ready` in 1: decoder accepts; transfer = valid & ready at the edge
- `redirect` in 1: load new PC, flush
- `redirect_pc` in ADDR_W: target PC
- `halted` out 1: high in HALTED state

## Operation
- States: IDLE, RUN, DRAIN, HALTED.
- Reset (`rst`=0, immediate) forces the following:
  - state=IDLE, PC=`RESET_PC`, `mem_addr`=`RESET_PC`
  - buffer empty, in-flight flag clear
  - `instr`=0, `instr_pc`=0, `instr_valid`=0, `halted`=0
- IDLE -> RUN when `enable`=1. In IDLE, `redirect` loads PC only.
- Issue (RUN only): allowed when occupancy + in-flight − pop-this-cycle < 2.
  - On issue, memory samples `mem_addr` at the edge.
  - PC increments by 1 at that edge, and the in-flight flag and in-flight PC are set.
- In-flight response: `mem_data` is written to the buffer with its PC at the next edge, and the in-flight flag clears unless a new issue occurs.
- PC wraps 8'hFF -> 8'h00 with no flag.
- HALT: a word with `instr[15:12]`=4'hF being written to the buffer causes the following:
  - The state goes to DRAIN and issuing stops.
  - Any response already in flight behind it is discarded.
  - The HALT word itself is still delivered.
- DRAIN -> HALTED when the buffer is empty. HALTED holds until reset or `redirect`.
- `redirect` in RUN/DRAIN/HALTED:
  - PC=`redirect_pc`, buffer flushed, in-flight response discarded, state=RUN, `halted`=0.
  - A handshake in the same cycle still counts as consumed.
  - `redirect` has priority over a HALT capture in the same cycle.
- `enable` is ignored outside IDLE.

## Timing
- `enable` sampled at edge E0 -> RUN.
- First issue (addr `RESET_PC`) at E1; word captured at E2; `instr_valid`=1 after E2.
- Latency address-issue to `instr_valid` = 2 edges.
- Sustained throughput 1 instr/cycle while `instr_ready`=1.
- `instr_ready` low: at most 2 words buffered (one possibly arriving from in-flight). No word is ever dropped or duplicated.
- `redirect` at edge R:
  - `instr_valid`=0 after R.
  - First issue of `redirect_pc` at R+1; valid after R+2.
- `halted` rises the edge the buffer becomes empty in DRAIN.
- Outputs are registered; `instr_valid` does not combinationally depend on `instr_ready`.

## Structure
- Package `fetch_pkg`: `ADDR_W`, `DATA_W`, `HALT_OPCODE`=4'hF, state enum type (IDLE/RUN/DRAIN/HALTED), buffer entry struct {pc, data}.
- Sub-module `fetch_buffer`: 2-entry FIFO of {pc, data}. It has push, pop, flush, count, and head outputs. Flush has priority over push.
- Top `fetch_unit` holds the FSM, PC, in-flight tracking and issue logic.

## Test plan
- Reset/start: hold `rst`=0, then release. Check all outputs at reset values. Pulse `enable` with `instr_ready`=1. `mem_addr` must go 0,1,2,3… and `instr_pc` must follow 0,1,2… two edges behind, with `instr` matching the memory contents.
- Backpressure: `instr_ready`=0 for 5 cycles mid-stream. Issue stops after 2 words are held. When ready returns, PCs continue contiguously with no gap or repeat.
- Redirect: at PC=5, assert `redirect` with `redirect_pc`=8'h40. Buffered PCs 4/5 are flushed, `instr_valid`=0 for 2 cycles, then `instr_pc`=8'h40, 8'h41…
- HALT: memory[3]=16'hF000. Words 0–3 are delivered, and `mem_addr` stops advancing past 4. `halted`=1 after word 3 is accepted. A later `redirect` to 8'h00 resumes fetch.
- Wrap: redirect to 8'hFE. Delivered PCs are FE, FF, 00, 01.
- Reset mid-operation: assert `rst` low asynchronously between edges with 2 words buffered. Outputs clear immediately, and after release with `enable`, fetch restarts at 8'h00.
